// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    RUN
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a little-endian byte stream into words; lane 0 lands in bits 7:0.
module word_packer
  import imem_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clear,
  input  logic                          push,
  input  logic [7:0]                    data,
  output logic [8*BYTES_PER_WORD-1:0]   word,
  output logic                          full
);

  logic [LANE_W-1:0]                 byte_cnt;
  logic [BYTES_PER_WORD-1:0][7:0]    lanes;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (push) begin
      lanes[byte_cnt] <= data;
      byte_cnt        <= byte_cnt + LANE_W'(1);
    end
  end

  // Asserted on the push that fills the last lane; byte_cnt wraps on that push.
  assign full = push && (byte_cnt == LANE_W'(BYTES_PER_WORD - 1));
  assign word = lanes;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: holds the core in reset, streams bytes into instruction memory,
// then releases the core and hands the memory port to instruction fetch.
module imem_loader
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_CAPACITY = 10,
  parameter int unsigned LEN_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len_words,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] core_A,
  input  logic                  core_en,
  output logic [DATA_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WD,
  output logic                  mem_WE,
  output logic                  mem_en,
  output logic                  core_rstn,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [LEN_WIDTH-1:0] CAP = LEN_WIDTH'(MEM_CAPACITY);

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   word_cnt;
  logic                   err_q;

  logic                   start_seen;
  logic                   start_zero;
  logic                   accept;
  logic                   reject;
  logic                   last_word;
  logic                   push;
  logic                   pk_full;
  logic [8*BYTES_PER_WORD-1:0] pk_word;

  // start is only honoured in IDLE and RUN; LOAD/WRITE ignore it entirely.
  assign start_seen = start && ((state_q == IDLE) || (state_q == RUN));
  assign start_zero = start_seen && (len_words == '0);
  assign accept     = start_seen && (len_words != '0) && (len_words <= CAP);
  assign reject     = start_seen && (len_words > CAP);
  assign last_word  = (word_cnt + LEN_WIDTH'(1)) == len_q;
  assign push       = (state_q == LOAD) && s_valid;

  word_packer u_packer (
    .clk   (clk),
    .rstn  (rstn),
    .clear (accept),
    .push  (push),
    .data  (s_data),
    .word  (pk_word),
    .full  (pk_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q    <= len_words;
        word_cnt <= '0;
      end else if ((state_q == WRITE) && !last_word) begin
        word_cnt <= word_cnt + LEN_WIDTH'(1);
      end
      if (reject) begin
        err_q <= 1'b1;
      end else if (start_zero || accept) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    mem_A     = '0;
    mem_WD    = '0;
    mem_WE    = 1'b0;
    mem_en    = 1'b0;
    core_rstn = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_zero) begin
          state_d = RUN;
        end else if (accept) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (pk_full) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy    = 1'b1;
        mem_WE  = 1'b1;
        mem_A   = DATA_WIDTH'(word_cnt);
        mem_WD  = DATA_WIDTH'(pk_word);
        state_d = last_word ? RUN : LOAD;
      end
      RUN: begin
        core_rstn = 1'b1;
        done      = 1'b1;
        mem_A     = core_A;
        mem_en    = core_en;
        if (accept) begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time controller for the core's instruction memory. After reset it holds the core in reset and accepts a little-endian byte stream over a valid/ready handshake. It packs the bytes into 32-bit words and writes them to consecutive word addresses of the instruction memory. When the load completes it releases the core and hands the memory port over to instruction fetch.

## Interface
Parameters:
- DATA_WIDTH, 32, word width of instruction memory (fixed at 32 for byte packing)
- MEM_CAPACITY, 10, number of words in instruction memory
- LEN_WIDTH, 16, width of the load-length input

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle load request; sampled in IDLE and RUN
- len_words  in  LEN_WIDTH  number of words to load; sampled with start
- s_valid  in  1  byte stream valid
- s_data  in  8  byte stream data
- s_ready  out  1  byte accepted when s_valid && s_ready
- core_A  in  DATA_WIDTH  core fetch word address
- core_en  in  1  core fetch enable
- mem_A  out  DATA_WIDTH  memory word address
- mem_WD  out  DATA_WIDTH  memory write data
- mem_WE  out  1  memory write enable
- mem_en  out  1  memory read enable
- core_rstn  out  1  active-low reset to core
- busy  out  1  high in LOAD and WRITE
- done  out  1  high in RUN
- err  out  1  sticky; set by an illegal len_words, cleared by a legal start

## Operation
- States: IDLE, LOAD, WRITE, RUN. Reset enters IDLE.
- IDLE: core_rstn=0; s_ready=0; mem_en=0.
  - start with len_words==0 -> RUN.
  - start with 1 <= len_words <= MEM_CAPACITY -> LOAD; latch len; clear word_cnt, byte_cnt and err.
  - start with len_words > MEM_CAPACITY -> set err; stay IDLE.
- LOAD: s_ready=1.
  - Each handshake stores s_data into byte lane byte_cnt, little-endian (lane 0 = bits 7:0).
  - byte_cnt increments on each handshake.
  - The handshake of lane 3 -> WRITE; byte_cnt wraps to 0.
  - s_valid low stalls indefinitely with no timeout.
- WRITE: s_ready=0; mem_WE=1; mem_A=word_cnt (zero-extended); mem_WD=assembled word.
  - If word_cnt+1 == len -> RUN; otherwise word_cnt++ and -> LOAD.
- RUN: core_rstn=1; mem_A=core_A; mem_en=core_en; mem_WE=0; mem_WD=0.
  - start is handled exactly as in IDLE, but the legal-length case -> LOAD with core_rstn low in the same cycle the state changes.
  - An illegal len_words in RUN sets err and stays in RUN.
- Outside RUN, core_A and core_en are ignored.
- Outside WRITE, mem_WE is 0.
- Memory words beyond len keep their prior contents.

## Timing
- Reset values: s_ready=0, mem_A=0, mem_WD=0, mem_WE=0, mem_en=0, core_rstn=0, busy=0, done=0, err=0.
- All outputs are decoded from registered state only; no combinational path from s_valid to s_ready.
- The RUN-state mux from core_A/core_en to mem_A/mem_en is combinational (zero latency).
- Throughput with back-to-back bytes: 5 cycles per word (4 LOAD cycles + 1 WRITE cycle).
- Load of N words: the first WRITE occurs 4 cycles after entering LOAD. RUN is entered on the edge after the final WRITE, so core_rstn rises 5N cycles after LOAD entry.
- rstn assertion mid-load: immediate return to IDLE; partial word discarded; the core stays in reset.
- start while in LOAD or WRITE is ignored.

## Structure
- Shared package imem_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, WRITE, RUN);
  - BYTES_PER_WORD=4;
  - the byte-lane index width.
- One sub-module, word_packer: byte_cnt plus a 32-bit shift/lane register. It has inputs push and data[7:0], outputs word and full, and a synchronous clear.
- The top level contains the FSM, word_cnt, the length latch and the port mux.

## Test plan
- Reset, then hold 20 cycles with no start -> core_rstn=0, s_ready=0, mem_WE=0, done=0 throughout.
- start with len_words=2, then bytes 78 56 34 12 EF BE AD DE back-to-back ->
  - WRITE (A=0, WD=0x12345678) at cycle 4;
  - WRITE (A=1, WD=0xDEADBEEF) at cycle 9;
  - core_rstn=1 and done=1 at cycle 10.
- Same load with s_valid deasserted for 3 cycles between bytes 2 and 3 -> the same writes, each delayed by 3 cycles; no extra mem_WE pulses.
- start with len_words=11 (MEM_CAPACITY=10) -> err=1, remains IDLE. A following start with len_words=1 clears err.
- In RUN, core_A=5 and core_en=1 -> mem_A=5, mem_en=1 in the same cycle. start with len_words=1 -> core_rstn=0 the next cycle, and a reload occurs.
- rstn pulsed low after 2 bytes of a word -> all outputs return to reset values; no write is issued.
